// File: rtl/ldpc_pkg.sv
// Shared types and constants for the LDPC iteration scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ldpc_pkg;

  localparam int NUM_PE     = 36;
  localparam int Z          = 6;
  localparam int DATA_WIDTH = 6;

  // Permutation network direction select
  localparam logic PERM_ROW = 1'b0;
  localparam logic PERM_COL = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_CN   = 3'd2,
    S_VN   = 3'd3,
    S_CHK  = 3'd4,
    S_DONE = 3'd5
  } sched_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ldpc_phase_cnt.sv
// Loadable down-counter timing one CN or VN phase; end_o flags its last cycle.
// Latency: end_o is combinational from the registered count (same cycle).
// Backpressure: none; counts only while en_i is high.
module ldpc_phase_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         end_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear beats load, load beats decrement; stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign end_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/ldpc_iter_sched.sv
// Sequences one LDPC decode job: 6-beat LLR load, CN/VN iterations, syndrome check, result handoff.
// Latency: 7 + k*(CNU_LAT+VNU_LAT+1) cycles from start to out_valid, plus LOAD stall cycles.
// Backpressure: in_valid=0 stalls LOAD; out_valid holds in DONE until out_ready.
module ldpc_iter_sched
  import ldpc_pkg::*;
#(
  parameter int MAX_ITER = 10,
  parameter int CNU_LAT  = 2,
  parameter int VNU_LAT  = 2,
  parameter int ITER_W   = $clog2(MAX_ITER + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [2:0]        load_row,
  output logic              load_we,
  output logic              perm_sel,
  output logic              cnu_en,
  output logic              vnu_en,
  input  logic              syndrome_ok,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              converged,
  output logic [ITER_W-1:0] iter_cnt
);

  localparam int                PH_W      = $clog2(max2(CNU_LAT, VNU_LAT) + 1);
  localparam logic [PH_W-1:0]   CN_LOAD   = PH_W'(CNU_LAT - 1);
  localparam logic [PH_W-1:0]   VN_LOAD   = PH_W'(VNU_LAT - 1);
  localparam logic [2:0]        LAST_ROW  = 3'(Z - 1);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(MAX_ITER);

  sched_state_t      state_q, state_d;
  logic [2:0]        load_row_q, load_row_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              conv_q, conv_d;
  logic              perm_q, perm_d;

  logic              ph_clr, ph_load, ph_en, ph_end;
  logic [PH_W-1:0]   ph_val;

  // Phase timer shared by CN and VN; reloaded on every phase entry.
  ldpc_phase_cnt #(.W(PH_W)) u_phase_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (ph_clr),
    .load_i     (ph_load),
    .load_val_i (ph_val),
    .en_i       (ph_en),
    .end_o      (ph_end)
  );

  assign ph_en = (state_q == S_CN) || (state_q == S_VN);

  // Next-state and counter updates; perm_sel only changes on CN/VN entry.
  always_comb begin
    state_d    = state_q;
    load_row_d = load_row_q;
    iter_d     = iter_q;
    conv_d     = conv_q;
    perm_d     = perm_q;
    ph_clr     = 1'b0;
    ph_load    = 1'b0;
    ph_val     = CN_LOAD;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LOAD;
          load_row_d = '0;
          iter_d     = '0;
          conv_d     = 1'b0;
          ph_clr     = 1'b1;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          if (load_row_q == LAST_ROW) begin
            state_d = S_CN;
            ph_load = 1'b1;
            ph_val  = CN_LOAD;
            perm_d  = PERM_ROW;
          end else begin
            load_row_d = load_row_q + 3'd1;
          end
        end
      end
      S_CN: begin
        if (ph_end) begin
          state_d = S_VN;
          ph_load = 1'b1;
          ph_val  = VN_LOAD;
          perm_d  = PERM_COL;
        end
      end
      S_VN: begin
        if (ph_end) begin
          state_d = S_CHK;
        end
      end
      S_CHK: begin
        iter_d = iter_q + ITER_W'(1);
        if (syndrome_ok) begin
          state_d = S_DONE;
          conv_d  = 1'b1;
        end else if ((iter_q + ITER_W'(1)) == ITER_LAST) begin
          state_d = S_DONE;
        end else begin
          state_d = S_CN;
          ph_load = 1'b1;
          ph_val  = CN_LOAD;
          perm_d  = PERM_ROW;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      load_row_q <= '0;
      iter_q     <= '0;
      conv_q     <= 1'b0;
      perm_q     <= PERM_ROW;
    end else begin
      state_q    <= state_d;
      load_row_q <= load_row_d;
      iter_q     <= iter_d;
      conv_q     <= conv_d;
      perm_q     <= perm_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign in_ready  = (state_q == S_LOAD);
  assign load_we   = in_valid & in_ready;
  assign load_row  = load_row_q;
  assign perm_sel  = perm_q;
  assign cnu_en    = (state_q == S_CN);
  assign vnu_en    = (state_q == S_VN);
  assign out_valid = (state_q == S_DONE);
  assign converged = conv_q;
  assign iter_cnt  = iter_q;

endmodule

// File: tb/tb_ldpc_iter_sched.sv
// Bench for ldpc_iter_sched: per-job timelines of expected outputs replayed cycle by cycle.
// Latency: n/a.
// Backpressure: out_ready delays are part of each generated job.
module tb_ldpc_iter_sched;

  localparam int MAX_ITER = 10;
  localparam int CNU_LAT  = 2;
  localparam int VNU_LAT  = 2;
  localparam int ITER_W   = $clog2(MAX_ITER + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start, in_valid, syndrome_ok, out_ready;
  logic              busy, in_ready, load_we, perm_sel, cnu_en, vnu_en, out_valid, converged;
  logic [2:0]        load_row;
  logic [ITER_W-1:0] iter_cnt;

  ldpc_iter_sched #(
    .MAX_ITER(MAX_ITER), .CNU_LAT(CNU_LAT), .VNU_LAT(VNU_LAT), .ITER_W(ITER_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .load_row(load_row), .load_we(load_we),
    .perm_sel(perm_sel), .cnu_en(cnu_en), .vnu_en(vnu_en), .syndrome_ok(syndrome_ok),
    .out_valid(out_valid), .out_ready(out_ready), .converged(converged), .iter_cnt(iter_cnt)
  );

  always #5 clk = ~clk;

  // Output bundle: {busy,in_ready,load_row[2:0],load_we,perm_sel,cnu_en,vnu_en,out_valid,converged,iter_cnt[3:0]}
  logic [14:0] got_w;
  assign got_w = {busy, in_ready, load_row, load_we, perm_sel, cnu_en, vnu_en,
                  out_valid, converged, iter_cnt};

  typedef struct {
    logic        st, iv, syn, rdy;
    logic [14:0] exp;
  } vec_t;

  vec_t vq[$];
  int   tests = 0;
  int   fails = 0;
  int   first_ov, first_cn, we_cnt;

  // Architectural view of the job as the model sees it
  logic [2:0]        m_row;
  logic [ITER_W-1:0] m_iter;
  logic              m_conv, m_perm;

  function automatic logic rb();
    return 1'($urandom_range(1));
  endfunction

  // Append one cycle: lbl is the phase the design should be in (I,L,C,V,K,D)
  task automatic add_vec(input byte lbl, input logic st, input logic iv,
                         input logic syn, input logic rdy);
    vec_t v;
    logic p;
    p = (lbl == "C") ? 1'b0 : (lbl == "V") ? 1'b1 : m_perm;
    v.st = st; v.iv = iv; v.syn = syn; v.rdy = rdy;
    v.exp = {lbl != "I", lbl == "L", m_row, (lbl == "L") && iv, p,
             lbl == "C", lbl == "V", lbl == "D", m_conv, m_iter};
    vq.push_back(v);
  endtask

  // lmode: 0 in_valid always 1, 1 three-cycle stall after beat 2, 2 random.
  // kconv: iteration whose CHK sees syndrome_ok=1 (0 = never).
  // noisy: start outside IDLE 0 never, 1 random, 2 always.
  task automatic build_job(input int lmode, input int kconv, input int dly, input int noisy);
    int   beats, n;
    logic iv, st;
    vq.delete();
    add_vec("I", 1'b1, rb(), rb(), rb());
    m_row = '0; m_iter = '0; m_conv = 1'b0;
    beats = 0; n = 0;
    while (beats < 6) begin
      if (lmode == 0)      iv = 1'b1;
      else if (lmode == 1) iv = (n < 3) || (n > 5);
      else                 iv = (n > 30) ? 1'b1 : ($urandom_range(3) != 0);
      st = (noisy == 2) ? 1'b1 : (noisy == 1) ? rb() : 1'b0;
      add_vec("L", st, iv, rb(), rb());
      if (iv) begin
        beats++;
        if (m_row < 3'd5) m_row = m_row + 3'd1;
      end
      n++;
    end
    for (int it = 1; it <= MAX_ITER; it++) begin
      for (int c = 0; c < CNU_LAT; c++) begin
        st = (noisy == 2) ? 1'b1 : (noisy == 1) ? rb() : 1'b0;
        add_vec("C", st, rb(), rb(), rb());
      end
      m_perm = 1'b0;
      for (int c = 0; c < VNU_LAT; c++) begin
        st = (noisy == 2) ? 1'b1 : (noisy == 1) ? rb() : 1'b0;
        add_vec("V", st, rb(), rb(), rb());
      end
      m_perm = 1'b1;
      st = (noisy == 2) ? 1'b1 : (noisy == 1) ? rb() : 1'b0;
      add_vec("K", st, rb(), it == kconv, rb());
      m_iter = ITER_W'(it);
      if (it == kconv) begin
        m_conv = 1'b1;
        break;
      end
    end
    for (int j = 0; j <= dly; j++) begin
      st = (noisy == 2) ? 1'b1 : (noisy == 1) ? rb() : 1'b0;
      add_vec("D", st, rb(), rb(), j == dly);
    end
    add_vec("I", 1'b0, rb(), rb(), rb());
    add_vec("I", 1'b0, rb(), rb(), rb());
  endtask

  // Replay the first upto entries (all if negative), one comparison per cycle
  task automatic run_job(input string name, input int upto);
    int n;
    n = (upto < 0) ? vq.size() : upto;
    first_ov = -1; first_cn = -1; we_cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      start = vq[i].st; in_valid = vq[i].iv; syndrome_ok = vq[i].syn; out_ready = vq[i].rdy;
      @(negedge clk);
      tests++;
      if (got_w !== vq[i].exp) begin
        fails++;
        $display("FAIL %s cycle %0d outputs got=%h exp=%h", name, i, got_w, vq[i].exp);
      end
      if (out_valid && first_ov < 0) first_ov = i;
      if (cnu_en && first_cn < 0) first_cn = i;
      if (load_we) we_cnt++;
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; syndrome_ok = 1'b0; out_ready = 1'b0;
    m_row = '0; m_iter = '0; m_conv = 1'b0; m_perm = 1'b0;
    #23;
    chk("reset_outputs", int'(got_w), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with start low for 20 cycles
    vq.delete();
    repeat (20) add_vec("I", 1'b0, rb(), rb(), rb());
    run_job("idle", -1);

    // Nominal: converge at first CHK
    build_job(0, 1, 0, 0);
    run_job("nominal", -1);
    chk("nominal_cn_cycle", first_cn, 7);
    chk("nominal_ov_cycle", first_ov, 12);
    chk("nominal_we_pulses", we_cnt, 6);

    // Never converges: runs all MAX_ITER iterations
    build_job(0, 0, 0, 0);
    run_job("nonconv", -1);
    chk("nonconv_ov_cycle", first_ov, 57);

    // Load stall of three cycles after beat 2
    build_job(1, 1, 0, 0);
    run_job("stall", -1);
    chk("stall_cn_cycle", first_cn, 10);
    chk("stall_we_pulses", we_cnt, 6);

    // Backpressure with start held high outside IDLE
    build_job(0, 2, 5, 2);
    run_job("backpressure", -1);
    chk("bp_ov_cycle", first_ov, 17);

    // Async reset mid-VN of iteration 3, then a clean job
    build_job(0, 0, 0, 0);
    run_job("midreset", 20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", int'(got_w), 0);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_row = '0; m_iter = '0; m_conv = 1'b0; m_perm = 1'b0;
    build_job(0, 3, 1, 0);
    run_job("after_reset", -1);
    chk("after_reset_ov_cycle", first_ov, 22);

    // Randomised jobs
    for (int j = 0; j < 25; j++) begin
      build_job(2, $urandom_range(MAX_ITER), $urandom_range(6), 1);
      run_job("random", -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
